// File: rtl/pin_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pin_arb_pkg                                            |
// | Description : Shared constants and state type for the pin arbiter.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package pin_arb_pkg;

   localparam int c_N_REQ_DEF    = 4;
   localparam int c_DATA_W_DEF   = 8;
   localparam int c_MAX_HOLD_DEF = 15;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] TURN  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_GRANT = GRANT,
      ST_TURN  = TURN
   } arb_state_t;

   // Position k steps after p in a ring of n slots; k < n and p < n.
   function automatic int f_ring_slot(input int p, input int k, input int n);
      int s;
      s = p + k;
      if (s >= n) begin
         s = s - n;
      end
      return s;
   endfunction

endpackage : pin_arb_pkg
`default_nettype wire

// File: rtl/pin_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_pick                                                |
// | Description : Combinational rotating-priority picker starting at ptr.|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module rr_pick
   import pin_arb_pkg::*;
#(
   parameter int N_REQ = c_N_REQ_DEF,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic             valid,
   output logic [N_REQ-1:0] sel,
   output logic [PTR_W-1:0] idx
);

   // Scan from the lowest priority upward so the slot nearest ptr wins last.
   always_comb begin
      valid = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[f_ring_slot(int'(ptr), k, N_REQ)]) begin
            valid = 1'b1;
            sel   = '0;
            sel[f_ring_slot(int'(ptr), k, N_REQ)] = 1'b1;
            idx   = PTR_W'(f_ring_slot(int'(ptr), k, N_REQ));
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/pin_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pin_arbiter                                            |
// | Description : Round-robin owner of a shared output pin bus with a    |
// |               hold limit and one turnaround cycle between owners.    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module pin_arbiter
   import pin_arb_pkg::*;
#(
   parameter int N_REQ    = c_N_REQ_DEF,
   parameter int DATA_W   = c_DATA_W_DEF,
   parameter int MAX_HOLD = c_MAX_HOLD_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] data_in,
   output logic [N_REQ-1:0]        grant,
   output logic [DATA_W-1:0]       bus_out,
   output logic                    busy,
   output logic                    timeout
);

   localparam int PTR_W  = $clog2(N_REQ);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   localparam logic [PTR_W-1:0]  c_LAST_IDX = PTR_W'(N_REQ - 1);
   localparam logic [HOLD_W-1:0] c_HOLD_END = HOLD_W'(MAX_HOLD - 1);

   arb_state_t        r_state,   w_state;
   logic [PTR_W-1:0]  r_ptr,     w_ptr;
   logic [PTR_W-1:0]  r_owner,   w_owner;
   logic [HOLD_W-1:0] r_hold,    w_hold;
   logic [N_REQ-1:0]  r_grant,   w_grant;
   logic              r_timeout, w_timeout;

   logic              w_valid;
   logic [N_REQ-1:0]  w_sel;
   logic [PTR_W-1:0]  w_idx;
   logic [PTR_W-1:0]  w_ptr_after_owner;
   logic [DATA_W-1:0] w_bus;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req   (req),
      .ptr   (r_ptr),
      .valid (w_valid),
      .sel   (w_sel),
      .idx   (w_idx)
   );

   assign w_ptr_after_owner = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_hold    <= '0;
         r_grant   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_ptr     <= w_ptr;
         r_owner   <= w_owner;
         r_hold    <= w_hold;
         r_grant   <= w_grant;
         r_timeout <= w_timeout;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_ptr     = r_ptr;
      w_owner   = r_owner;
      w_hold    = r_hold;
      w_grant   = r_grant;
      w_timeout = 1'b0;

      case (r_state)
         ST_IDLE, ST_TURN: begin
            if (w_valid) begin
               w_state = ST_GRANT;
               w_grant = w_sel;
               w_owner = w_idx;
               w_hold  = '0;
            end else begin
               w_state = ST_IDLE;
               w_grant = '0;
            end
         end

         ST_GRANT: begin
            // Release takes precedence so a voluntary drop never flags a timeout.
            if (!req[r_owner]) begin
               w_state = ST_TURN;
               w_grant = '0;
               w_ptr   = w_ptr_after_owner;
               w_hold  = '0;
            end else if (r_hold == c_HOLD_END) begin
               w_state   = ST_TURN;
               w_grant   = '0;
               w_ptr     = w_ptr_after_owner;
               w_hold    = '0;
               w_timeout = 1'b1;
            end else begin
               w_hold = r_hold + 1'b1;
            end
         end

         default: begin
            w_state = ST_IDLE;
            w_grant = '0;
            w_hold  = '0;
         end
      endcase
   end

   always_comb begin
      w_bus = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant[i]) begin
            w_bus = w_bus | data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   assign grant   = r_grant;
   assign bus_out = w_bus;
   assign busy    = |r_grant;
   assign timeout = r_timeout;

endmodule : pin_arbiter
`default_nettype wire

// File: tb/tb_pin_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pin_arbiter                                         |
// | Description : Scoreboard bench for pin_arbiter, MAX_HOLD 3 and 15.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_pin_arbiter;

   localparam int c_N  = 4;
   localparam int c_DW = 8;
   localparam int c_HA = 3;
   localparam int c_HB = 15;

   typedef struct packed {
      logic [3:0] g0;
      logic [7:0] b0;
      logic       y0;
      logic       t0;
      logic [3:0] g1;
      logic [7:0] b1;
      logic       y1;
      logic       t1;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] data_in;

   logic [3:0]  grant_a, grant_b;
   logic [7:0]  bus_a, bus_b;
   logic        busy_a, busy_b;
   logic        to_a, to_b;

   exp_t        r_sb[$];
   int          n_tests;
   int          n_fail;
   int          to_cnt_a;
   int          to_cnt_b;

   int          m_st[2];
   int          m_ptr[2];
   int          m_own[2];
   int          m_cnt[2];
   bit          m_to[2];

   pin_arbiter #(.N_REQ(c_N), .DATA_W(c_DW), .MAX_HOLD(c_HA)) u_dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .data_in (data_in),
      .grant   (grant_a),
      .bus_out (bus_a),
      .busy    (busy_a),
      .timeout (to_a)
   );

   pin_arbiter #(.N_REQ(c_N), .DATA_W(c_DW), .MAX_HOLD(c_HB)) u_dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .data_in (data_in),
      .grant   (grant_b),
      .bus_out (bus_b),
      .busy    (busy_b),
      .timeout (to_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference: cnt counts grant cycles already served (1..maxh).
   task automatic model_step(input int m, input int maxh, input logic [3:0] r, input logic rn);
      bit found;
      int w;
      if (!rn) begin
         m_st[m]  = 0;
         m_ptr[m] = 0;
         m_own[m] = 0;
         m_cnt[m] = 0;
         m_to[m]  = 1'b0;
      end else begin
         m_to[m] = 1'b0;
         if (m_st[m] == 1) begin
            if (!r[m_own[m]]) begin
               m_st[m]  = 2;
               m_ptr[m] = (m_own[m] + 1) % c_N;
            end else if (m_cnt[m] == maxh) begin
               m_st[m]  = 2;
               m_ptr[m] = (m_own[m] + 1) % c_N;
               m_to[m]  = 1'b1;
            end else begin
               m_cnt[m] = m_cnt[m] + 1;
            end
         end else begin
            found = 1'b0;
            for (int k = 0; k < c_N; k++) begin
               w = (m_ptr[m] + k) % c_N;
               if (!found && r[w]) begin
                  found    = 1'b1;
                  m_own[m] = w;
               end
            end
            if (found) begin
               m_st[m]  = 1;
               m_cnt[m] = 1;
            end else begin
               m_st[m] = 0;
            end
         end
      end
   endtask

   task automatic cycle(input logic [3:0] r, input logic rn, input bit pin_a5);
      exp_t e;
      exp_t o;
      logic [31:0] d;
      d = $urandom;
      if (pin_a5) d[23:16] = 8'hA5;
      req     = r;
      rst_n   = rn;
      data_in = d;
      model_step(0, c_HA, r, rn);
      model_step(1, c_HB, r, rn);
      e.g0 = (m_st[0] == 1) ? (4'b0001 << m_own[0]) : 4'b0000;
      e.b0 = (m_st[0] == 1) ? d[m_own[0]*8 +: 8] : 8'h00;
      e.y0 = (m_st[0] == 1);
      e.t0 = m_to[0];
      e.g1 = (m_st[1] == 1) ? (4'b0001 << m_own[1]) : 4'b0000;
      e.b1 = (m_st[1] == 1) ? d[m_own[1]*8 +: 8] : 8'h00;
      e.y1 = (m_st[1] == 1);
      e.t1 = m_to[1];
      r_sb.push_back(e);
      @(posedge clk);
      #1;
      chk("sb_depth", r_sb.size(), 1);
      if (r_sb.size() > 0) begin
         o = r_sb.pop_front();
         chk("a_grant",   grant_a, o.g0);
         chk("a_bus",     bus_a,   o.b0);
         chk("a_busy",    busy_a,  o.y0);
         chk("a_timeout", to_a,    o.t0);
         chk("b_grant",   grant_b, o.g1);
         chk("b_bus",     bus_b,   o.b1);
         chk("b_busy",    busy_b,  o.y1);
         chk("b_timeout", to_b,    o.t1);
      end
      if (to_a) to_cnt_a++;
      if (to_b) to_cnt_b++;
   endtask

   task automatic run(input logic [3:0] r, input int n);
      for (int i = 0; i < n; i++) cycle(r, 1'b1, 1'b0);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      to_cnt_a = 0;
      to_cnt_b = 0;
      rst_n    = 1'b0;
      req      = '0;
      data_in  = '0;

      for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 1'b0);
      run(4'b0000, 10);

      for (int i = 0; i < 4; i++) cycle(4'b0100, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 1'b1);

      run(4'b1111, 30);
      run(4'b0000, 3);

      to_cnt_a = 0;
      to_cnt_b = 0;
      run(4'b0010, 40);
      run(4'b0000, 3);
      chk("hog_timeouts_a", to_cnt_a, 10);
      chk("hog_timeouts_b", to_cnt_b, 2);

      run(4'b1000, 1);
      run(4'b1101, 1);
      run(4'b0101, 5);
      run(4'b0000, 3);

      run(4'b0110, 3);
      cycle(4'b0110, 1'b0, 1'b0);
      run(4'b0110, 4);
      run(4'b0000, 3);

      for (int i = 0; i < 300; i++) begin
         cycle(4'($urandom), ($urandom_range(0, 49) != 0), 1'b0);
      end
      run(4'b0000, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pin_arbiter
`default_nettype wire

// File: doc/pin_arbiter.md
# pin_arbiter

Round-robin arbiter that shares one 8-bit output pin bus among up to N student sub-designs in the workshop tile. Each requester raises `req` and presents its data; the arbiter grants the bus to one owner at a time, enforces a maximum hold time, and inserts one turnaround cycle between owners. It sits between the per-student Wokwi cell netlists and the tile's `uo_out` pins.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, width of each requester's data and of the shared bus
- MAX_HOLD, 15, maximum consecutive grant cycles per ownership (>= 1)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset: synchronous, active-low, sampled on rising `clk`
- req  in  N_REQ  request per requester; level-held while bus is wanted
- data_in  in  N_REQ*DATA_W  requester i's data in bits [i*DATA_W +: DATA_W]
- grant  out  N_REQ  one-hot current owner, all-zero when no owner; registered
- bus_out  out  DATA_W  owner's `data_in` slice, zero when `grant` is all-zero
- busy  out  1  high when `grant` is nonzero
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD

## Operation
- States: IDLE, GRANT, TURN.
- Arbitration (IDLE and TURN): winner = first `req[i]` set scanning i = ptr, ptr+1, ... modulo N_REQ. No request -> no winner.
- IDLE: `grant` = 0. Winner present -> GRANT with `grant` = onehot(winner), owner = winner, hold_cnt = 0. Else stay IDLE.
- GRANT: hold_cnt increments each cycle in GRANT.
  - `req[owner]` sampled low -> TURN; ptr = (owner+1) mod N_REQ.
  - else hold_cnt == MAX_HOLD-1 -> TURN; ptr = (owner+1) mod N_REQ; `timeout` high for the first TURN cycle.
  - else stay GRANT. Other requesters' `req` changes are ignored.
- TURN: `grant` = 0 for exactly one cycle; arbitration is evaluated with the updated ptr. Winner -> GRANT (new owner, hold_cnt = 0); none -> IDLE.
- A timed-out requester still holding `req` competes normally. It is regranted only when no requester between it and itself (in ptr order) is requesting; if it is the sole requester, it is regranted after TURN.
- `bus_out` is a combinational mux of `data_in` selected by registered `grant`; all-zero in IDLE and TURN.
- hold_cnt width is $clog2(MAX_HOLD+1); it never wraps.
- ptr width is $clog2(N_REQ); the increment wraps N_REQ-1 -> 0.

## Timing
- Reset (rst_n low at an edge): state IDLE, ptr 0, hold_cnt 0, `grant` 0, `bus_out` 0, `busy` 0, `timeout` 0. Reset mid-grant drops `grant` on that edge and applies no turnaround.
- Request latency: `req` high before edge t in IDLE -> `grant` high after edge t (1 cycle).
- Release: `req[owner]` low before edge t -> `grant` 0 after edge t. The next owner's `grant` is high after edge t+1 at the earliest.
- Maximum ownership: MAX_HOLD consecutive cycles of `grant`. `timeout` coincides with the TURN cycle.
- Simultaneous requests at one edge are resolved only by ptr order.
- A requester that drops and re-raises `req` inside one TURN cycle is treated as requesting.

## Structure
- Shared package `pin_arb_pkg` holds:
  - state encoding constants IDLE=2'd0, GRANT=2'd1, TURN=2'd2
  - default parameter constants
- Sub-module `rr_pick` is combinational: inputs `req` vector and ptr; outputs `valid`, one-hot `sel` and binary `idx`. It is instantiated once.
- Top level holds the state register, ptr, hold_cnt, owner index and output mux.

## Test plan
- Reset then idle: no req for 10 cycles -> `grant`=0, `bus_out`=0, `busy`=0 throughout.
- Single requester: req[2]=1 with data 8'hA5 for 4 cycles then low -> `grant`=4'b0100 for 4 cycles starting 1 cycle after req, `bus_out`=8'hA5, then one TURN cycle and IDLE.
- Round robin: req=4'b1111 held with MAX_HOLD=3 -> owners 0,1,2,3,0 in order, each 3 cycles, one zero cycle between them, `timeout` pulse on each TURN.
- Sole hog: req[1] held high for 40 cycles, MAX_HOLD=15 -> `grant` 15 on, 1 off, 15 on, 1 off; `timeout` at cycles 16 and 32 after the first grant.
- Pointer wrap: owner 3 releases while req[0] and req[2] are high -> next grant is 0 after one TURN cycle.
- Reset mid-operation: rst_n low during GRANT of requester 1 with req=4'b0110 -> `grant`=0 after that edge. After release, first grant goes to requester 1 (ptr=0 scan).
